// File: rtl/fir_decim_out.sv
// fir_decim_out
//   Output stage behind a FIR filter: decimates the sample stream by DECIM,
//   scales each kept sample by a rounded arithmetic right shift of SHIFT bits,
//   saturates it to OUT_WIDTH bits and queues it in a small FIFO for a
//   valid/ready consumer.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   clr        synchronous clear, same effect as rst
//   in_valid   in_data carries a sample this cycle
//   in_data    signed filtered sample (WIDTH bits)
//   out_valid  out_data holds the FIFO head
//   out_ready  consumer accepts the head this cycle
//   out_data   signed scaled, decimated sample (OUT_WIDTH bits)
//   sat_flag   sticky: some kept sample was saturated
//   ovf_flag   sticky: some kept sample was dropped on a full FIFO
//   drop_cnt   number of dropped samples, saturates at 16'hFFFF
//
// Handshake: a transfer happens on a rising edge where out_valid && out_ready.
// out_valid depends only on registered occupancy, never on out_ready, and
// out_data is held stable while out_valid && !out_ready.

module fir_decim_out #(
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 6,
  parameter int DECIM     = 4,
  parameter int DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        in_valid,
  input  logic signed [WIDTH-1:0]     in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        sat_flag,
  output logic                        ovf_flag,
  output logic [15:0]                 drop_cnt
);

  localparam int PHW  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  // Scaling works one bit wider than the input so adding the rounding
  // constant to the most positive sample cannot wrap.
  localparam logic signed [WIDTH:0] RND     = (WIDTH + 1)'(1) << (SHIFT - 1);
  localparam logic signed [WIDTH:0] SAT_MAX =
    {{(WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [WIDTH:0] SAT_MIN =
    {{(WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  // ---------------------------------------------------------------------
  // Decimation phase and scaling (combinational)
  // ---------------------------------------------------------------------
  logic [PHW-1:0]              r_phase;
  logic                        w_keep;
  logic signed [WIDTH:0]       w_ext;
  logic signed [WIDTH:0]       w_sum;
  logic signed [WIDTH:0]       w_shr;
  logic signed [OUT_WIDTH-1:0] w_scaled;
  logic                        w_sat;

  assign w_keep = in_valid && (r_phase == PHW'(DECIM - 1));
  assign w_ext  = {in_data[WIDTH-1], in_data};
  assign w_sum  = w_ext + RND;
  assign w_shr  = w_sum >>> SHIFT;

  always_comb begin
    w_scaled = w_shr[OUT_WIDTH-1:0];
    w_sat    = 1'b0;
    if (w_shr > SAT_MAX) begin
      w_scaled = SAT_MAX[OUT_WIDTH-1:0];
      w_sat    = 1'b1;
    end else if (w_shr < SAT_MIN) begin
      w_scaled = SAT_MIN[OUT_WIDTH-1:0];
      w_sat    = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: phase counter and registered scaled sample
  // ---------------------------------------------------------------------
  logic                        r_s1_valid;
  logic signed [OUT_WIDTH-1:0] r_s1_data;
  logic                        r_sat_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase    <= '0;
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_sat_flag <= 1'b0;
    end else if (clr) begin
      r_phase    <= '0;
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_sat_flag <= 1'b0;
    end else begin
      if (in_valid) begin
        if (r_phase == PHW'(DECIM - 1)) r_phase <= '0;
        else                            r_phase <= r_phase + PHW'(1);
      end
      r_s1_valid <= w_keep;
      if (w_keep) begin
        r_s1_data <= w_scaled;
        if (w_sat) r_sat_flag <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: output FIFO
  // ---------------------------------------------------------------------
  logic signed [OUT_WIDTH-1:0] r_mem [DEPTH];
  logic [PTRW-1:0]             r_wptr;
  logic [PTRW-1:0]             r_rptr;
  logic [CNTW-1:0]             r_count;
  logic                        r_ovf_flag;
  logic [15:0]                 r_drop_cnt;
  logic                        w_full;
  logic                        w_pop;
  logic                        w_push;
  logic                        w_drop;

  assign w_full = (r_count == CNTW'(DEPTH));
  assign w_pop  = out_valid && out_ready;
  // A pop on a full FIFO frees the head slot on the same edge, so the write
  // may land in it.
  assign w_push = r_s1_valid && (!w_full || w_pop);
  assign w_drop = r_s1_valid && w_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_ovf_flag <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_ovf_flag <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= r_s1_data;
        r_wptr        <= r_wptr + PTRW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PTRW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNTW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNTW'(1);
      if (w_drop) begin
        r_ovf_flag <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rptr];
  assign sat_flag  = r_sat_flag;
  assign ovf_flag  = r_ovf_flag;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_fir_decim_out.sv
// tb_fir_decim_out
//   Directed bench for fir_decim_out with DECIM=4, SHIFT=4, OUT_WIDTH=16,
//   DEPTH=4. Inputs change 2 ns after the rising edge; outputs are read on
//   the falling edge. Expected output samples are queued in exp_q and
//   consumed by a monitor whenever a transfer is about to happen.

module tb_fir_decim_out;

  logic               clk;
  logic               rst;
  logic               clr;
  logic               in_valid;
  logic signed [31:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               sat_flag;
  logic               ovf_flag;
  logic [15:0]        drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic signed [15:0] exp_q[$];

  fir_decim_out #(
    .WIDTH(32), .OUT_WIDTH(16), .SHIFT(4), .DECIM(4), .DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat_flag(sat_flag), .ovf_flag(ovf_flag), .drop_cnt(drop_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", 32'(out_data), 32'hDEAD);
      else                   check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Three filler samples then the kept one; returns just after the kept
  // sample was captured, with in_valid low.
  task automatic send_group(input logic signed [31:0] v);
    for (int i = 0; i < 3; i++) begin
      tick(); in_valid = 1'b1; in_data = 32'sd0;
    end
    tick(); in_valid = 1'b1; in_data = v;
    tick(); in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_ovf", ovf_flag, 0);
    check("rst_drop", drop_cnt, 0);

    // Ramp 16*n: every fourth sample kept, scaled by 1/16 with rounding.
    out_ready = 1'b1;
    exp_q.push_back(16'sd3); exp_q.push_back(16'sd7);
    exp_q.push_back(16'sd11); exp_q.push_back(16'sd15);
    for (int n = 0; n < 16; n++) begin
      tick(); in_valid = 1'b1; in_data = 32'(16 * n);
    end
    tick(); in_valid = 1'b0;
    drain();

    // Rounding half toward +inf, with latency check on the first group.
    exp_q.push_back(16'sd2); exp_q.push_back(-16'sd1);
    exp_q.push_back(16'sd1); exp_q.push_back(16'sd0);
    send_group(32'sd24);
    @(negedge clk); check("lat_edge1_invalid", out_valid, 0);
    @(negedge clk); check("lat_edge2_valid", out_valid, 1);
    send_group(-32'sd24);
    send_group(32'sd8);
    send_group(-32'sd8);
    drain();
    check("round_no_sat", sat_flag, 0);

    // Saturation at both rails, flag sticky.
    exp_q.push_back(16'sd32767); exp_q.push_back(-16'sd32768);
    send_group(32'sh7FFFFFFF);
    send_group(32'sh80000000);
    drain();
    check("sat_set", sat_flag, 1);
    exp_q.push_back(16'sd1);
    send_group(32'sd16);
    drain();
    check("sat_sticky", sat_flag, 1);

    // Six kept samples with consumer stalled: four stored, two dropped.
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) send_group(32'(16 * k));
    repeat (2) @(negedge clk);
    check("stall_drop_cnt", drop_cnt, 2);
    check("stall_ovf", ovf_flag, 1);
    check("stall_valid", out_valid, 1);
    check("stall_head", out_data, 1);
    tick(); out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) exp_q.push_back(16'(k));
    drain();

    // Full FIFO with a pop on the same edge as the write: nothing dropped.
    out_ready = 1'b0;
    for (int k = 7; k <= 10; k++) send_group(32'(16 * k));
    repeat (2) @(negedge clk);
    check("full_drop_before", drop_cnt, 2);
    for (int k = 7; k <= 11; k++) exp_q.push_back(16'(k));
    send_group(32'sd176);
    out_ready = 1'b1;
    drain();
    check("full_pop_drop", drop_cnt, 2);
    check("full_pop_ovf", ovf_flag, 1);

    // in_valid gaps: phase counter holds while in_valid is low.
    exp_q.push_back(16'sd4);
    for (int k = 1; k <= 4; k++) begin
      tick(); in_valid = 1'b1; in_data = 32'(16 * k);
      tick(); in_valid = 1'b0; in_data = 32'sd999;
    end
    drain();

    // Async reset with three entries queued and phase mid-count.
    out_ready = 1'b0;
    send_group(32'sd80); send_group(32'sd96); send_group(32'sd112);
    repeat (2) @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    tick(); in_valid = 1'b1; in_data = 32'sd16;
    tick(); in_valid = 1'b1; in_data = 32'sd32;
    tick(); in_valid = 1'b0; rst = 1'b1;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_data", out_data, 0);
    check("rst_async_sat", sat_flag, 0);
    check("rst_async_ovf", ovf_flag, 0);
    check("rst_async_drop", drop_cnt, 0);
    tick(); rst = 1'b0; out_ready = 1'b1;
    exp_q.push_back(16'sd23);
    for (int k = 20; k <= 23; k++) begin
      tick(); in_valid = 1'b1; in_data = 32'(16 * k);
    end
    tick(); in_valid = 1'b0;
    drain();

    // Synchronous clear discards queued data.
    out_ready = 1'b0;
    send_group(32'sd80);
    repeat (2) @(negedge clk);
    check("pre_clr_valid", out_valid, 1);
    tick(); clr = 1'b1;
    tick(); clr = 1'b0;
    @(negedge clk);
    check("clr_valid", out_valid, 0);
    out_ready = 1'b1;
    exp_q.push_back(16'sd9);
    send_group(32'sd144);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
